// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter and sequencer that shares one uart_tx between NUM_REQ
//   byte requesters. One byte is accepted per valid/ready handshake and handed
//   to the transmitter with a single-cycle start pulse; the transmitter busy
//   flag is tracked so that only one frame is ever in flight.
//
// Parameters
//   NUM_REQ       number of requesters (2..8)
//   BUSY_TIMEOUT  cycles to wait for i_tx_busy to rise after start (1..255)
//
// Ports
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    per-requester byte valid, held until ready
//   i_req_data     byte for requester k on [8k+7:8k]
//   i_req_lock     keep the grant for the next byte (lock build only)
//   o_req_ready    accept strobe, transfer = valid & ready
//   o_grant        one-hot current owner, 0 when idle
//   o_tx_data      byte to uart_tx
//   o_tx_start     single-cycle start pulse to uart_tx
//   i_tx_busy      busy flag from uart_tx
//   o_active       high in every state except IDLE
//   o_err_timeout  single-cycle pulse when busy never rose after start
//
// Build option
//   UART_ARB_LOCK_EN  adds the LOCKED state so a requester holding i_req_lock
//                     keeps ownership across consecutive bytes.
//------------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned BUSY_TIMEOUT = 7
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [8*NUM_REQ-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]   i_req_lock,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic [7:0]           o_tx_data,
   output logic                 o_tx_start,
   input  logic                 i_tx_busy,
   output logic                 o_active,
   output logic                 o_err_timeout
);

   localparam int unsigned PW = $clog2(NUM_REQ);
   localparam logic [PW:0]   NREQ_W   = (PW+1)'(NUM_REQ);
   localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ-1);
   localparam logic [7:0]    TMO      = 8'(BUSY_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE
`ifdef UART_ARB_LOCK_EN
      , S_LOCKED
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [PW-1:0]       owner_q, owner_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [7:0]          data_q, data_d;
   logic [7:0]          cnt_q, cnt_d;

   logic                win_found;
   logic [PW-1:0]       win_idx;
   logic                sel_valid;
   logic [7:0]          sel_data;
   logic [PW-1:0]       ptr_next;

   // Rotating priority search: index (ptr + i) mod NUM_REQ, first valid wins.
   always_comb begin
      logic [PW:0] sum;
      win_found = 1'b0;
      win_idx   = '0;
      sum       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(i);
         if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
         end
         if (!win_found && i_req_valid[sum[PW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = sum[PW-1:0];
         end
      end
   end

   // Owner's request lines, selected by the registered owner index.
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (owner_q == PW'(k)) begin
            sel_valid = i_req_valid[k];
            sel_data  = i_req_data[k*8 +: 8];
         end
      end
   end

`ifdef UART_ARB_LOCK_EN
   logic sel_lock;
   always_comb begin
      sel_lock = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (owner_q == PW'(k)) begin
            sel_lock = i_req_lock[k];
         end
      end
   end
`else
   logic unused_lock;
   assign unused_lock = ^i_req_lock;
`endif

   assign ptr_next = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         grant_q <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      grant_d       = grant_q;
      data_d        = data_q;
      cnt_d         = cnt_q;
      o_req_ready   = '0;
      o_tx_start    = 1'b0;
      o_err_timeout = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Busy high here means a frame from before reset is still draining.
            if (win_found && !i_tx_busy) begin
               grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
               owner_d = win_idx;
               state_d = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            o_req_ready = grant_q;
            if (sel_valid) begin
               data_d  = sel_data;
               ptr_d   = ptr_next;
               state_d = S_START;
            end else begin
               // Requester withdrew: give up the slot without moving the pointer.
               grant_d = '0;
               state_d = S_IDLE;
            end
         end
         S_START: begin
            o_tx_start = 1'b1;
            cnt_d      = '0;
            state_d    = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (i_tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (cnt_q == TMO) begin
               o_err_timeout = 1'b1;
               grant_d       = '0;
               state_d       = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WAIT_DONE: begin
            if (!i_tx_busy) begin
`ifdef UART_ARB_LOCK_EN
               if (sel_lock) begin
                  state_d = S_LOCKED;
               end else begin
                  grant_d = '0;
                  state_d = S_IDLE;
               end
`else
               grant_d = '0;
               state_d = S_IDLE;
`endif
            end
         end
`ifdef UART_ARB_LOCK_EN
         S_LOCKED: begin
            if (sel_valid) begin
               state_d = S_ACCEPT;
            end else if (!sel_lock) begin
               grant_d = '0;
               state_d = S_IDLE;
            end
         end
`endif
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_grant   = grant_q;
   assign o_tx_data = data_q;
   assign o_active  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Scoreboard bench for uart_tx_arbiter. Requesters are modelled by per-port
//   byte quotas; a small uart_tx model raises busy one cycle after start and
//   holds it for FRAME cycles. Expected transmissions and timeouts go into a
//   scoreboard queue; expected output snapshots go into a second queue. A
//   negedge monitor pops and compares both.
//------------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned FRAME = 4;

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b0;
   logic [NREQ-1:0]   i_req_valid;
   logic [8*NREQ-1:0] req_data = '0;
   logic [NREQ-1:0]   i_req_lock;
   logic [NREQ-1:0]   o_req_ready;
   logic [NREQ-1:0]   o_grant;
   logic [7:0]        o_tx_data;
   logic              o_tx_start;
   logic              i_tx_busy;
   logic              o_active;
   logic              o_err_timeout;

   uart_tx_arbiter #(
      .NUM_REQ      (NREQ),
      .BUSY_TIMEOUT (7)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_req_valid   (i_req_valid),
      .i_req_data    (req_data),
      .i_req_lock    (i_req_lock),
      .o_req_ready   (o_req_ready),
      .o_grant       (o_grant),
      .o_tx_data     (o_tx_data),
      .o_tx_start    (o_tx_start),
      .i_tx_busy     (i_tx_busy),
      .o_active      (o_active),
      .o_err_timeout (o_err_timeout)
   );

   always #5 i_clk = ~i_clk;

   // Requesters: valid while bytes remain in the quota and not killed.
   int unsigned     quota [NREQ];
   int unsigned     sent  [NREQ];
   logic [NREQ-1:0] kill = '0;
   logic [NREQ-1:0] lock_en = '0;

   initial begin
      for (int k = 0; k < NREQ; k++) begin
         quota[k] = 0;
         sent[k]  = 0;
      end
   end

   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         i_req_valid[k] = (sent[k] < quota[k]) && !kill[k];
      end
   end
   assign i_req_lock = lock_en & i_req_valid;

   always @(posedge i_clk) begin
      for (int k = 0; k < NREQ; k++) begin
         if (i_req_valid[k] && o_req_ready[k]) sent[k] <= sent[k] + 1;
      end
   end

   // uart_tx model.
   logic        model_busy = 1'b0;
   int unsigned bcnt = 0;
   logic        suppress = 1'b0;
   logic        force_busy = 1'b0;

   always @(posedge i_clk) begin
      if (o_tx_start && !suppress) begin
         model_busy <= 1'b1;
         bcnt       <= FRAME;
      end else if (bcnt != 0) begin
         bcnt <= bcnt - 1;
         if (bcnt == 1) model_busy <= 1'b0;
      end
   end
   assign i_tx_busy = model_busy | force_busy;

   // Scoreboard and snapshot queues.
   typedef struct packed {
      logic       is_to;
      logic [3:0] grant;
      logic [7:0] data;
      logic [7:0] delta;
   } exp_t;

   typedef struct packed {
      logic [1:0]  kind;     // 0 outputs, 1 wait result, 2 drained
      logic [31:0] tag;
      logic [3:0]  grant;
      logic [3:0]  ready;
      logic        active;
      logic        start;
      logic        err;
      logic        chk_data;
      logic [7:0]  data;
   } snap_t;

   exp_t  sb [$];
   snap_t snq [$];

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc = 0;
   int unsigned start_cyc = 0;

   task automatic chk(input logic [31:0] tag, input logic [31:0] fld,
                      input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h (t=%0t)", tag, fld, act, exp, $time);
      end
   endtask

   always @(negedge i_clk) begin
      exp_t  e;
      snap_t s;
      cyc++;
      if (o_tx_start) begin
         if (sb.size() == 0) begin
            chk("SB  ", "xst ", 32'(sb.size()), 1);
         end else begin
            e = sb.pop_front();
            chk("SB  ", "kind", {31'd0, e.is_to}, 0);
            chk("SB  ", "sgnt", {28'd0, o_grant}, {28'd0, e.grant});
            chk("SB  ", "sdat", {24'd0, o_tx_data}, {24'd0, e.data});
         end
         start_cyc = cyc;
      end
      if (o_err_timeout) begin
         if (sb.size() == 0) begin
            chk("SB  ", "xto ", 32'(sb.size()), 1);
         end else begin
            e = sb.pop_front();
            chk("SB  ", "kind", {31'd0, e.is_to}, 1);
            chk("SB  ", "tgnt", {28'd0, o_grant}, {28'd0, e.grant});
            chk("SB  ", "tdly", cyc - start_cyc, {24'd0, e.delta});
         end
      end
      while (snq.size() > 0) begin
         s = snq.pop_front();
         case (s.kind)
            2'd0: begin
               chk(s.tag, "gnt ", {28'd0, o_grant}, {28'd0, s.grant});
               chk(s.tag, "rdy ", {28'd0, o_req_ready}, {28'd0, s.ready});
               chk(s.tag, "act ", {31'd0, o_active}, {31'd0, s.active});
               chk(s.tag, "stt ", {31'd0, o_tx_start}, {31'd0, s.start});
               chk(s.tag, "err ", {31'd0, o_err_timeout}, {31'd0, s.err});
               if (s.chk_data) chk(s.tag, "dat ", {24'd0, o_tx_data}, {24'd0, s.data});
            end
            2'd1: chk(s.tag, "wait", {31'd0, s.active}, 1);
            default: begin
               chk(s.tag, "sbq ", 32'(sb.size()), 0);
               chk(s.tag, "vld ", {28'd0, i_req_valid}, 0);
            end
         endcase
      end
   end

   // Stimulus helpers.
   task automatic push_st(input logic [3:0] g, input logic [7:0] d);
      exp_t e;
      e.is_to = 1'b0; e.grant = g; e.data = d; e.delta = '0;
      sb.push_back(e);
   endtask

   task automatic push_to(input logic [3:0] g, input logic [7:0] dly);
      exp_t e;
      e.is_to = 1'b1; e.grant = g; e.data = '0; e.delta = dly;
      sb.push_back(e);
   endtask

   task automatic snap(input logic [1:0] kind, input logic [31:0] tag,
                       input logic [3:0] g, input logic [3:0] r, input logic a,
                       input logic st, input logic er, input logic cd,
                       input logic [7:0] d);
      snap_t s;
      s.kind = kind; s.tag = tag; s.grant = g; s.ready = r; s.active = a;
      s.start = st; s.err = er; s.chk_data = cd; s.data = d;
      snq.push_back(s);
   endtask

   task automatic do_reset(input logic [31:0] tag);
      kill = '0; lock_en = '0; suppress = 1'b0; force_busy = 1'b0;
      for (int k = 0; k < NREQ; k++) quota[k] = sent[k];
      @(posedge i_clk); #1;
      i_rst_n = 1'b0;
      snap(2'd0, tag, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      @(posedge i_clk); @(posedge i_clk); #1;
      i_rst_n = 1'b1;
   endtask

   task automatic wait_idle(input logic [31:0] tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge i_clk);
         if (i_req_valid == '0 && !o_active && !i_tx_busy) begin
            ok = 1'b1;
            break;
         end
      end
      snap(2'd1, tag, '0, '0, ok, 1'b0, 1'b0, 1'b0, '0);
      snap(2'd2, tag, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic wait_start(input logic [31:0] tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge i_clk);
         if (o_tx_start) begin
            ok = 1'b1;
            break;
         end
      end
      snap(2'd1, tag, '0, '0, ok, 1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // 1: single byte from requester 2, cycle-exact latency.
      do_reset("RST1");
      req_data = 32'h00A5_0000;
      push_st(4'b0100, 8'hA5);
      @(posedge i_clk); #1;
      quota[2] = sent[2] + 1;
      snap(2'd0, "T1N0", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge i_clk); #1;
      snap(2'd0, "T1N1", 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge i_clk); #1;
      snap(2'd0, "T1N2", 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
      @(posedge i_clk); #1;
      snap(2'd0, "T1N3", 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
      wait_idle("T1W ");

      // 2: all four requesting, pointer wraps 3 -> 0.
      do_reset("RST2");
      req_data = 32'h4433_2211;
      push_st(4'b0001, 8'h11);
      push_st(4'b0010, 8'h22);
      push_st(4'b0100, 8'h33);
      push_st(4'b1000, 8'h44);
      push_st(4'b0001, 8'h11);
      @(posedge i_clk); #1;
      quota[0] = sent[0] + 2;
      for (int k = 1; k < NREQ; k++) quota[k] = sent[k] + 1;
      wait_idle("T2W ");

      // 3: valid withdrawn during ACCEPT, then re-asserted.
      do_reset("RST3");
      req_data = 32'h0000_2200;
      @(posedge i_clk); #1;
      quota[1] = sent[1] + 1;
      @(posedge i_clk); #1;
      kill[1] = 1'b1;
      snap(2'd0, "T3AC", 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge i_clk); #1;
      snap(2'd0, "T3AB", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      push_st(4'b0010, 8'h22);
      kill[1] = 1'b0;
      wait_idle("T3W ");

      // 4: busy never rises, timeout 8 cycles after start.
      do_reset("RST4");
      req_data = 32'h0000_00C4;
      suppress = 1'b1;
      push_st(4'b0001, 8'hC4);
      push_to(4'b0001, 8'd8);
      @(posedge i_clk); #1;
      quota[0] = sent[0] + 1;
      wait_idle("T4W ");

      // 5: reset in WAIT_DONE while the transmitter stays busy.
      do_reset("RST5");
      req_data = 32'h5C00_00A0;
      push_st(4'b1000, 8'h5C);
      @(posedge i_clk); #1;
      quota[3] = sent[3] + 1;
      wait_start("T5S ");
      @(posedge i_clk); @(posedge i_clk); #1;
      force_busy = 1'b1;
      quota[0] = sent[0] + 1;
      #1;
      i_rst_n = 1'b0;
      snap(2'd0, "T5R ", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         snap(2'd0, "T5H ", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         @(posedge i_clk); #1;
      end
      push_st(4'b0001, 8'hA0);
      force_busy = 1'b0;
      wait_idle("T5W ");

      // 6: requester 0 holds lock for three bytes, requester 1 competing.
      do_reset("RST6");
      req_data = 32'h0000_6160;
      lock_en  = 4'b0001;
`ifdef UART_ARB_LOCK_EN
      push_st(4'b0001, 8'h60);
      push_st(4'b0001, 8'h60);
      push_st(4'b0001, 8'h60);
      push_st(4'b0010, 8'h61);
      push_st(4'b0010, 8'h61);
`else
      push_st(4'b0001, 8'h60);
      push_st(4'b0010, 8'h61);
      push_st(4'b0001, 8'h60);
      push_st(4'b0010, 8'h61);
      push_st(4'b0001, 8'h60);
`endif
      @(posedge i_clk); #1;
      quota[0] = sent[0] + 3;
      quota[1] = sent[1] + 2;
      wait_idle("T6W ");

      repeat (3) @(negedge i_clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
